// File: rtl/snap_pkg.sv
// Shared definitions for the ADC snapshot capture block and its status register wrapper.
// Holds the capture state encoding and the ctrl/status word bit positions.
package snap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } snap_state_e;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_TRIG_EXT  = 1;
    localparam int CTRL_VLD_GATE  = 2;
    localparam int CTRL_CIRC      = 3;

    localparam int STAT_DONE      = 31;
    localparam int STAT_STATE_HI  = 30;
    localparam int STAT_STATE_LO  = 29;
    localparam int STAT_WRAPPED   = 28;

endpackage

// File: rtl/adcsnap_capture_ctrl.sv
// Snapshot capture sequencer: arms on enable rise, waits for trigger, writes samples to BRAM.
// BRAM port is registered (1 cycle after the write decision); no backpressure, writes are fire-and-forget.
module adcsnap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_word,
    input  logic              trig_in,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_word
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    snap_state_e       state_q, state_d;
    logic              en_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_data_q, bram_data_d;

    logic en, rise, fall, trigger, wr;
    logic ctrl_unused;

    assign en          = ctrl_word[CTRL_EN];
    assign rise        = en & ~en_q;
    assign fall        = ~en & en_q;
    assign trigger     = ctrl_word[CTRL_TRIG_EXT] ? trig_in : 1'b1;
    assign wr          = ctrl_word[CTRL_VLD_GATE] ? din_valid : 1'b1;
    assign ctrl_unused = ^ctrl_word[31:4];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_data_d = bram_data_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rise) begin
                    state_d   = ST_ARMED;
                    addr_d    = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (trigger) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (wr) begin
                    bram_we_d   = 1'b1;
                    bram_addr_d = addr_q;
                    bram_data_d = din;
                    addr_d      = addr_q + 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    if (addr_q == ADDR_LAST) begin
                        if (ctrl_word[CTRL_CIRC]) begin
                            wrapped_d = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                // The write in the fall cycle above still goes out before stopping.
                if (fall) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en;
            addr_q      <= addr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_data_q <= bram_data_d;
        end
    end

    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_data = bram_data_q;

    assign status_word = {(state_q == ST_DONE), state_q, wrapped_q,
                          {(28 - CNT_W){1'b0}}, count_q};

endmodule

// File: tb/tb_adcsnap_capture_ctrl.sv
// Directed bench for adcsnap_capture_ctrl with a 16-word buffer.
module tb_adcsnap_capture_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic [31:0]   ctrl_word;
    logic          trig_in;
    logic          din_valid;
    logic [DW-1:0] din;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;
    logic [31:0]   status_word;

    int checks = 0;
    int errors = 0;

    adcsnap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .user_clk    (clk),
        .user_rst_n  (rst_n),
        .ctrl_word   (ctrl_word),
        .trig_in     (trig_in),
        .din_valid   (din_valid),
        .din         (din),
        .bram_addr   (bram_addr),
        .bram_data   (bram_data),
        .bram_we     (bram_we),
        .status_word (status_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ctrl_word = '0; trig_in = 1'b0; din_valid = 1'b0; din = '0;
        tick(); tick();
        checks++;
        if (status_word !== 32'd0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: status=%h we=%b addr=%h data=%h, want all 0",
                     status_word, bram_we, bram_addr, bram_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (status_word !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle: status=%h want 0", status_word);
        end
    endtask

    task automatic test_oneshot();
        ctrl_word = 32'h1;
        tick();
        checks++;
        if (status_word[30:29] !== 2'd1) begin
            errors++;
            $display("FAIL oneshot_armed: state=%0d want 1", status_word[30:29]);
        end
        tick();
        checks++;
        if (status_word[30:29] !== 2'd2) begin
            errors++;
            $display("FAIL oneshot_capture: state=%0d want 2", status_word[30:29]);
        end
        for (int i = 0; i < 16; i++) begin
            din = 16'hA000 + 16'(i);
            tick();
            checks++;
            if (bram_we !== 1'b1 || bram_addr !== AW'(i) || bram_data !== 16'hA000 + 16'(i)) begin
                errors++;
                $display("FAIL oneshot_write%0d: we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         i, bram_we, bram_addr, bram_data, i, 16'hA000 + 16'(i));
            end
        end
        checks++;
        if (status_word !== {1'b1, 2'd3, 1'b0, 23'd0, 5'd16}) begin
            errors++;
            $display("FAIL oneshot_done_status: status=%h want %h", status_word,
                     {1'b1, 2'd3, 1'b0, 23'd0, 5'd16});
        end
        din = 16'hFFFF;
        tick();
        checks++;
        if (bram_we !== 1'b0 || status_word[30:29] !== 2'd3) begin
            errors++;
            $display("FAIL oneshot_we_off: we=%b state=%0d want we=0 state=3", bram_we, status_word[30:29]);
        end
        ctrl_word = 32'h0;
        tick();
    endtask

    task automatic test_ext_trigger();
        ctrl_word = 32'h3;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (status_word[30:29] !== 2'd1 || bram_we !== 1'b0) begin
                errors++;
                $display("FAIL trig_wait%0d: state=%0d we=%b want state=1 we=0", i, status_word[30:29], bram_we);
            end
        end
        trig_in = 1'b1;
        din = 16'h5A5A;
        tick();
        trig_in = 1'b0;
        checks++;
        if (status_word[30:29] !== 2'd2 || bram_we !== 1'b0) begin
            errors++;
            $display("FAIL trig_capture: state=%0d we=%b want state=2 we=0", status_word[30:29], bram_we);
        end
        tick();
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== '0 || bram_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL trig_first_write: we=%b addr=%0d data=%h want we=1 addr=0 data=5a5a",
                     bram_we, bram_addr, bram_data);
        end
        ctrl_word = 32'h2;
        tick();
        checks++;
        if (status_word !== {1'b1, 2'd3, 1'b0, 23'd0, 5'd2}) begin
            errors++;
            $display("FAIL trig_abort_status: status=%h want %h", status_word, {1'b1, 2'd3, 1'b0, 23'd0, 5'd2});
        end
        ctrl_word = 32'h0;
        tick();
    endtask

    task automatic test_vld_gate();
        ctrl_word = 32'h5;
        tick();
        checks++;
        if (status_word !== {1'b0, 2'd1, 1'b0, 28'd0}) begin
            errors++;
            $display("FAIL gate_rearm_clear: status=%h want %h", status_word, {1'b0, 2'd1, 1'b0, 28'd0});
        end
        tick();
        for (int i = 0; i < 32; i++) begin
            din_valid = (i % 2 == 0);
            din = 16'h0100 + 16'(i);
            tick();
            checks++;
            if (i % 2 == 0) begin
                if (bram_we !== 1'b1 || bram_addr !== AW'(i / 2) || bram_data !== 16'h0100 + 16'(i)) begin
                    errors++;
                    $display("FAIL gate_write%0d: we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                             i, bram_we, bram_addr, bram_data, i / 2, 16'h0100 + 16'(i));
                end
            end else if (bram_we !== 1'b0) begin
                errors++;
                $display("FAIL gate_idle%0d: we=%b want 0", i, bram_we);
            end
        end
        din_valid = 1'b0;
        checks++;
        if (status_word !== {1'b1, 2'd3, 1'b0, 23'd0, 5'd16}) begin
            errors++;
            $display("FAIL gate_done_status: status=%h want %h", status_word, {1'b1, 2'd3, 1'b0, 23'd0, 5'd16});
        end
        ctrl_word = 32'h0;
        tick();
    endtask

    task automatic test_circular();
        int writes;
        writes = 0;
        ctrl_word = 32'h9;
        tick();
        tick();
        for (int i = 0; i < 39; i++) begin
            din = 16'(i);
            tick();
            if (bram_we === 1'b1) writes++;
        end
        checks++;
        if (status_word !== {1'b0, 2'd2, 1'b1, 23'd0, 5'd16}) begin
            errors++;
            $display("FAIL circ_running: status=%h want %h", status_word, {1'b0, 2'd2, 1'b1, 23'd0, 5'd16});
        end
        // The fall cycle carries the 40th write, at address 39 mod 16.
        ctrl_word = 32'h8;
        din = 16'd39;
        tick();
        if (bram_we === 1'b1) writes++;
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== 4'd7 || bram_data !== 16'd39 || writes != 40) begin
            errors++;
            $display("FAIL circ_last_write: we=%b addr=%0d data=%0d writes=%0d want we=1 addr=7 data=39 writes=40",
                     bram_we, bram_addr, bram_data, writes);
        end
        checks++;
        if (status_word !== {1'b1, 2'd3, 1'b1, 23'd0, 5'd16}) begin
            errors++;
            $display("FAIL circ_done_status: status=%h want %h", status_word, {1'b1, 2'd3, 1'b1, 23'd0, 5'd16});
        end
        tick();
        checks++;
        if (bram_we !== 1'b0) begin
            errors++;
            $display("FAIL circ_we_off: we=%b want 0", bram_we);
        end
        ctrl_word = 32'h0;
    endtask

    task automatic test_abort();
        ctrl_word = 32'h1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            din = 16'h0B00 + 16'(i);
            tick();
        end
        ctrl_word = 32'h0;
        din = 16'h0B04;
        tick();
        checks++;
        if (status_word !== {1'b1, 2'd3, 1'b0, 23'd0, 5'd5} || bram_we !== 1'b1 ||
            bram_addr !== 4'd4 || bram_data !== 16'h0B04) begin
            errors++;
            $display("FAIL abort_status: status=%h we=%b addr=%0d data=%h want status=%h we=1 addr=4 data=0b04",
                     status_word, bram_we, bram_addr, bram_data, {1'b1, 2'd3, 1'b0, 23'd0, 5'd5});
        end
        tick();
        checks++;
        if (bram_we !== 1'b0 || status_word[4:0] !== 5'd5) begin
            errors++;
            $display("FAIL abort_hold: we=%b count=%0d want we=0 count=5", bram_we, status_word[4:0]);
        end
        ctrl_word = 32'h1;
        tick();
        checks++;
        if (status_word !== {1'b0, 2'd1, 1'b0, 28'd0}) begin
            errors++;
            $display("FAIL abort_rearm_clear: status=%h want %h", status_word, {1'b0, 2'd1, 1'b0, 28'd0});
        end
        // Fall and immediate trigger together in ARMED: fall takes priority.
        ctrl_word = 32'h0;
        tick();
        checks++;
        if (status_word[30:29] !== 2'd0 || bram_we !== 1'b0) begin
            errors++;
            $display("FAIL fall_beats_trigger: state=%0d we=%b want state=0 we=0", status_word[30:29], bram_we);
        end
    endtask

    task automatic test_reset_mid_capture();
        ctrl_word = 32'h1;
        tick();
        tick();
        din = 16'hC0DE;
        tick();
        checks++;
        if (bram_we !== 1'b1 || status_word[30:29] !== 2'd2) begin
            errors++;
            $display("FAIL rst_pre_write: we=%b state=%0d want we=1 state=2", bram_we, status_word[30:29]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bram_we !== 1'b0 || status_word !== 32'd0) begin
            errors++;
            $display("FAIL rst_immediate: we=%b status=%h want we=0 status=0", bram_we, status_word);
        end
        ctrl_word = 32'h0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bram_we !== 1'b0 || status_word !== 32'd0) begin
                errors++;
                $display("FAIL rst_stay_idle%0d: we=%b status=%h want we=0 status=0", i, bram_we, status_word);
            end
        end
        ctrl_word = 32'h1;
        tick();
        checks++;
        if (status_word[30:29] !== 2'd1) begin
            errors++;
            $display("FAIL rst_rearm: state=%0d want 1", status_word[30:29]);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_ext_trigger();
        test_vld_gate();
        test_circular();
        test_abort();
        test_reset_mid_capture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
